// File: rtl/shift_register_sequencer_if.sv
// shift_register_sequencer_if: command handshake between a host and the shift register sequencer
interface shift_register_sequencer_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [1:0]       cmd_fill;
    logic [CNT_W-1:0] cmd_count;
    logic             abort;
    modport master (
        output cmd_valid, cmd_load, cmd_data, cmd_dir, cmd_fill, cmd_count, abort,
        input  cmd_ready
    );
    modport slave (
        input  cmd_valid, cmd_load, cmd_data, cmd_dir, cmd_fill, cmd_count, abort,
        output cmd_ready
    );
endinterface

// File: rtl/shift_register_sequencer.sv
// shift_register_sequencer: runs load/shift commands against an external universal shift register
module shift_register_sequencer #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    shift_register_sequencer_if.slave cmd,
    output logic [1:0]                sr_sel,
    output logic [WIDTH-1:0]          sr_in,
    output logic                      sr_leftshift,
    output logic                      sr_rightshift,
    input  logic [WIDTH-1:0]          sr_q,
    output logic                      sout,
    output logic                      sout_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [1:0]       fill_q;
    logic [CNT_W-1:0] cnt_q;
    logic             aborted_q;
    logic             out_bit;
    logic             fill_bit;

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= state_nx;

    // next state: abort or an exhausted counter closes the command
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd.cmd_valid) state_nx = cmd.cmd_load ? LOAD : (cmd.cmd_count != '0 ? SHIFT : DONE);
            LOAD:    state_nx = (cmd.abort || cnt_q == '0) ? DONE : SHIFT;
            SHIFT:   if (cmd.abort || cnt_q == CNT_W'(1)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // command capture, shift down-counter and abort flag for the DONE cycle
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            data_q    <= '0;
            dir_q     <= 1'b0;
            fill_q    <= '0;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (state == IDLE && cmd.cmd_valid) begin
                data_q <= cmd.cmd_data;
                dir_q  <= cmd.cmd_dir;
                fill_q <= cmd.cmd_fill;
                cnt_q  <= cmd.cmd_count;
            end
            if (state == SHIFT) cnt_q <= cnt_q - 1'b1;
            aborted_q <= (state == LOAD || state == SHIFT) && cmd.abort;
        end

    // outputs: register controls from state, serial bits from the live register value
    always_comb begin
        out_bit       = dir_q ? sr_q[0] : sr_q[WIDTH-1];
        fill_bit      = fill_q == 2'b01 || (fill_q == 2'b10 && out_bit);
        cmd.cmd_ready = state == IDLE;
        busy          = state != IDLE;
        done          = state == DONE;
        aborted       = state == DONE && aborted_q;
        sr_sel        = state == LOAD ? 2'b11 : state == SHIFT ? (dir_q ? 2'b10 : 2'b01) : 2'b00;
        sr_in         = state == LOAD ? data_q : '0;
        sout_valid    = state == SHIFT;
        sout          = sout_valid && out_bit;
        sr_leftshift  = sout_valid && !dir_q && fill_bit;
        sr_rightshift = sout_valid && dir_q && fill_bit;
    end
endmodule

// File: tb/tb_shift_register_sequencer.sv
// tb_shift_register_sequencer: randomized and directed checks of the sequencer against a command-level model
module tb_shift_register_sequencer;
    localparam int W  = 2;
    localparam int CW = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   sr_sel;
    logic [W-1:0] sr_in;
    logic         sr_leftshift, sr_rightshift, sout, sout_valid, busy, done, aborted;
    logic [W-1:0] reg_q = '0;
    logic [W-1:0] model_q = '0;
    int           total = 0;
    int           bad = 0;

    shift_register_sequencer_if #(.WIDTH(W), .CNT_W(CW)) cmd_if ();

    shift_register_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
        .cmd(cmd_if),
        .sr_sel(sr_sel),
        .sr_in(sr_in),
        .sr_leftshift(sr_leftshift),
        .sr_rightshift(sr_rightshift),
        .sr_q(reg_q),
        .sout(sout),
        .sout_valid(sout_valid),
        .busy(busy),
        .done(done),
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    // external universal shift register; keeps its contents across sequencer reset
    always @(posedge clk)
        case (sr_sel)
            2'b01:   reg_q <= {reg_q[W-2:0], sr_leftshift};
            2'b10:   reg_q <= {sr_rightshift, reg_q[W-1:1]};
            2'b11:   reg_q <= sr_in;
            default: reg_q <= reg_q;
        endcase

    wire [W+9:0] obs = {sr_sel, sr_in, sout_valid, sout, sr_leftshift, sr_rightshift, busy, done, aborted, cmd_if.cmd_ready};
    wire [W+9:0] idle_v = {2'b00, W'(0), 8'b0000_0001};

    task automatic run_cmd(input bit ld, input logic [W-1:0] d, input bit dr, input logic [1:0] fl,
                           input logic [CW-1:0] cnt, input int ab, input bit hold, input string tag);
        int m, eo, fb, k;
        bit ab_hit;
        logic [W+9:0] exp_v;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_load  = ld;
        cmd_if.cmd_data  = d;
        cmd_if.cmd_dir   = dr;
        cmd_if.cmd_fill  = fl;
        cmd_if.cmd_count = cnt;
        @(posedge clk); #1;
        if (hold) begin
            cmd_if.cmd_load  = 1'b0;
            cmd_if.cmd_count = '0;
            cmd_if.cmd_data  = ~d;
        end else begin
            cmd_if.cmd_valid = 1'b0;
            cmd_if.cmd_load  = 1'($urandom);
            cmd_if.cmd_data  = W'($urandom);
            cmd_if.cmd_dir   = 1'($urandom);
            cmd_if.cmd_fill  = 2'($urandom);
            cmd_if.cmd_count = CW'($urandom);
        end
        m = int'(model_q);
        k = 1;
        ab_hit = 1'b0;
        if (ld) begin
            cmd_if.abort = (ab == k);
            exp_v = {2'b11, d, 8'b0000_1000};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL %s load cycle: got %b want %b", tag, obs, exp_v);
            end
            @(posedge clk); #1;
            cmd_if.abort = 1'b0;
            m = int'(d);
            ab_hit = (ab == k);
            k++;
        end
        for (int i = 0; i < int'(cnt) && !ab_hit; i++) begin
            cmd_if.abort = (ab == k);
            eo = dr ? m & 1 : (m >> (W - 1)) & 1;
            fb = fl == 2'b01 ? 1 : fl == 2'b10 ? eo : 0;
            exp_v = {dr ? 2'b10 : 2'b01, W'(0), 1'b1, eo[0], !dr && fb[0], dr && fb[0], 4'b1000};
            total++;
            if (obs !== exp_v) begin
                bad++;
                $display("FAIL %s shift %0d: got %b want %b", tag, i, obs, exp_v);
            end
            @(posedge clk); #1;
            cmd_if.abort = 1'b0;
            m = dr ? (m >> 1) | (fb << (W - 1)) : ((m << 1) | fb) & ((1 << W) - 1);
            ab_hit = (ab == k);
            k++;
        end
        cmd_if.abort = 1'($urandom);
        exp_v = {2'b00, W'(0), 4'b0000, 1'b1, 1'b1, ab_hit, 1'b0};
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s done cycle %0d: got %b want %b", tag, k, obs, exp_v);
        end
        @(posedge clk); #1;
        cmd_if.abort = 1'b0;
        model_q = W'(m);
        total++;
        if (obs !== idle_v) begin
            bad++;
            $display("FAIL %s idle after done: got %b want %b", tag, obs, idle_v);
        end
        total++;
        if (reg_q !== model_q) begin
            bad++;
            $display("FAIL %s register: got %b want %b", tag, reg_q, model_q);
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        total++;
        if (obs !== idle_v) begin
            bad++;
            $display("FAIL reset values: got %b want %b", obs, idle_v);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        total++;
        if (obs !== idle_v) begin
            bad++;
            $display("FAIL idle after reset: got %b want %b", obs, idle_v);
        end
    endtask

    task automatic test_directed;
        run_cmd(1'b1, 2'b10, 1'b1, 2'b00, 4'd1, 0, 1'b0, "load_right_zero");
        run_cmd(1'b1, 2'b10, 1'b0, 2'b10, 4'd2, 0, 1'b0, "load_left_rotate");
        run_cmd(1'b1, 2'b00, 1'b0, 2'b00, 4'd0, 0, 1'b0, "clear");
        run_cmd(1'b0, 2'b00, 1'b0, 2'b01, 4'd3, 0, 1'b0, "left_one_fill");
        run_cmd(1'b1, 2'b11, 1'b0, 2'b00, 4'd0, 0, 1'b0, "load_count_zero");
        run_cmd(1'b0, 2'b00, 1'b1, 2'b11, 4'd0, 0, 1'b0, "empty_command");
        run_cmd(1'b0, 2'b00, 1'b1, 2'b10, 4'd15, 0, 1'b0, "max_count_rotate");
    endtask

    task automatic test_abort;
        run_cmd(1'b1, 2'b10, 1'b1, 2'b00, 4'd5, 3, 1'b1, "abort_in_shift");
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        total++;
        if (obs !== {2'b00, W'(0), 8'b0000_1100}) begin
            bad++;
            $display("FAIL held command after abort: got %b want %b", obs, {2'b00, W'(0), 8'b0000_1100});
        end
        @(posedge clk); #1;
        total++;
        if (obs !== idle_v) begin
            bad++;
            $display("FAIL idle after held command: got %b want %b", obs, idle_v);
        end
        run_cmd(1'b1, 2'b01, 1'b0, 2'b01, 4'd4, 1, 1'b0, "abort_in_load");
    endtask

    task automatic test_reset_mid;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_load  = 1'b1;
        cmd_if.cmd_data  = 2'b10;
        cmd_if.cmd_dir   = 1'b1;
        cmd_if.cmd_fill  = 2'b00;
        cmd_if.cmd_count = 4'd5;
        @(posedge clk); #1;
        cmd_if.cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs !== idle_v) begin
            bad++;
            $display("FAIL async reset mid shift: got %b want %b", obs, idle_v);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_q = 2'b01;
        total++;
        if (reg_q !== model_q) begin
            bad++;
            $display("FAIL register after reset: got %b want %b", reg_q, model_q);
        end
        @(posedge clk); #1;
        total++;
        if (obs !== idle_v) begin
            bad++;
            $display("FAIL ready after reset release: got %b want %b", obs, idle_v);
        end
        run_cmd(1'b0, 2'b00, 1'b0, 2'b01, 4'd2, 0, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        bit           ld, dr;
        logic [W-1:0] d;
        logic [1:0]   fl;
        logic [CW-1:0] cnt;
        int           span, ab;
        for (int n = 0; n < 40; n++) begin
            ld   = 1'($urandom);
            d    = W'($urandom);
            dr   = 1'($urandom);
            fl   = 2'($urandom);
            cnt  = CW'($urandom_range(0, 7));
            span = int'(ld) + int'(cnt);
            ab   = (span > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, span)) : 0;
            run_cmd(ld, d, dr, fl, cnt, ab, 1'b0, "random");
        end
    endtask

    initial begin
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_load  = 1'b0;
        cmd_if.cmd_data  = '0;
        cmd_if.cmd_dir   = 1'b0;
        cmd_if.cmd_fill  = '0;
        cmd_if.cmd_count = '0;
        cmd_if.abort     = 1'b0;
        test_reset;
        test_directed;
        test_abort;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/shift_register_sequencer.md
# shift_register_sequencer

Command-driven sequencer for the universal shift register (sel encoding 00 hold, 01 shift left, 10 shift right, 11 parallel load). It accepts one command at a time over a valid/ready handshake. Each command optionally parallel-loads a word, then shifts it a programmed number of positions with zero-fill, one-fill or rotate. The block drives the register's `sel`, parallel-data and serial-input ports, reads back the register's `out`, and reports each bit shifted out. It sits between a serializer/host and an external register instance.

## Interface
- `WIDTH`, 2: shift register width.
- `CNT_W`, 4: width of the shift-count field. Maximum shift count is 2^CNT_W-1.
- `clk`  in  1: clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `cmd_valid`  in  1: command present.
- `cmd_ready`  out  1: block can accept a command. High only in IDLE.
- `cmd_load`  in  1: 1 = parallel-load `cmd_data` before shifting.
- `cmd_data`  in  WIDTH: word to load.
- `cmd_dir`  in  1: 0 = shift left, 1 = shift right.
- `cmd_fill`  in  2: 00 zero-fill, 01 one-fill, 10 rotate, 11 reserved (treated as zero-fill).
- `cmd_count`  in  CNT_W: number of shift cycles.
- `abort`  in  1: terminate the current command.
- `sr_sel`  out  2: to the register's `sel`.
- `sr_in`  out  WIDTH: to the register's parallel input.
- `sr_leftshift`  out  1: serial input entering the LSB on a left shift.
- `sr_rightshift`  out  1: serial input entering the MSB on a right shift.
- `sr_q`  in  WIDTH: register's `out`.
- `sout`  out  1: bit leaving the register this cycle.
- `sout_valid`  out  1: `sout` is meaningful.
- `busy`  out  1: state is not IDLE.
- `done`  out  1: one-cycle completion pulse.
- `aborted`  out  1: qualifies `done`. The command ended by `abort`.

## Operation
- States are IDLE, LOAD, SHIFT and DONE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid && cmd_ready`, capture `cmd_load`, `cmd_data`, `cmd_dir`, `cmd_fill` and `cmd_count`.
  - Next state: LOAD if load=1, else SHIFT if count≠0, else DONE.
- LOAD:
  - `sr_sel`=11 and `sr_in`=captured data, for exactly one cycle.
  - Next state: SHIFT if count≠0, else DONE.
- SHIFT:
  - `sr_sel`=01 (dir=0) or 10 (dir=1), held for exactly `count` cycles.
  - An internal down-counter is loaded with `count`. On the final cycle (counter=1) the next state is DONE.
- DONE:
  - `sr_sel`=00 and `done`=1 for one cycle, then IDLE.
  - `aborted`=1 in DONE only if entered via `abort`.
- Serial fill:
  - Zero-fill drives the active serial input to 0; one-fill drives it to 1.
  - Rotate, left shift: `sr_leftshift`=`sr_q[WIDTH-1]`.
  - Rotate, right shift: `sr_rightshift`=`sr_q[0]`.
  - The inactive serial input is always 0.
- Shift-out:
  - In SHIFT, `sout_valid`=1.
  - `sout`=`sr_q[WIDTH-1]` for a left shift, `sr_q[0]` for a right shift. This is the bit the register discards at this edge.
  - Outside SHIFT, `sout_valid`=0 and `sout`=0.
- `count` may exceed WIDTH; extra shifts keep filling.
- Abort:
  - `abort` sampled high in LOAD or SHIFT → DONE at the next edge with `aborted`=1.
  - The current cycle's `sr_sel` still takes effect.
  - `abort` is ignored in IDLE and DONE.
- Outside LOAD/SHIFT: `sr_sel`=00 and `sr_in`=0.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `sr_sel`=00, `sr_in`=0, both serial inputs 0, `sout`=0, `sout_valid`=0, `busy`=0, `done`=0, `aborted`=0, all captured fields 0.
- Reset asserted mid-command returns to IDLE immediately with the values above. The register contents are not restored.
- `sr_sel`, `sr_in`, `busy`, `done` and `cmd_ready` decode from registered state only. No combinational path exists from `cmd_*` or `abort`.
- `sr_leftshift`, `sr_rightshift` and `sout` are combinational from `sr_q` in rotate/shift-out. This is a legal path because `sr_q` is registered in the register instance.
- Latency from acceptance edge to `done` = load + count + 1 cycles:
  - load=1, count=3 → done in the 5th cycle after acceptance.
  - load=0, count=0 → done in the 1st cycle.
- `cmd_ready` returns high the cycle after `done`. The minimum command-to-command spacing is therefore latency + 1.

## Test plan
- Reset, then load 2'b10, right shift, count 1, zero-fill → `sr_sel` sequence 11, 10, 00. Register 10→01. `sout`=0. `done` 3 cycles after acceptance.
- Load 10, left rotate, count 2 → register 10→01→10. `sout` sequence 1, 0. `sr_leftshift` sequence 1, 0. `aborted`=0.
- No load (register=00), left one-fill, count 3 → register 01, 11, 11. `sout` sequence 0, 0, 1.
- Load 11, count 0 → LOAD then DONE. No `sout_valid` pulses. Register=11.
- Load 10, right zero-fill, count 5; `abort` in the 2nd SHIFT cycle → exactly 2 shift-right cycles, then `done`=1 with `aborted`=1. `cmd_valid` held throughout is not accepted until IDLE.
- Assert `reset` in the middle of SHIFT → all outputs reach reset values without waiting for a clock edge. `cmd_ready`=1 after reset is released, and the next command executes normally.
